// File: rtl/decode_operand_stage_if.sv
// decode_operand_stage_if: signals between the decode stage and its
// neighbours (IF/ID latch, register file, EX/MEM, ID/EX register).
interface decode_operand_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              if_valid;
    logic [15:0]       if_instr;
    logic              flush;
    logic [REG_AW-1:0] RA;
    logic [REG_AW-1:0] RB;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] BusB;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wen;
    logic              ex_is_load;
    logic [DATA_W-1:0] ex_result;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_result;
    logic              stall;
    logic              id_valid;
    logic              id_wen;
    logic              id_is_load;
    logic              id_is_store;
    logic              id_is_branch;
    logic              id_is_jump;
    logic [3:0]        id_opcode;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_opA;
    logic [DATA_W-1:0] id_opB;
    logic [DATA_W-1:0] id_imm;

    modport master (
        output if_valid, if_instr, flush, BusA, BusB,
        output ex_rd, ex_wen, ex_is_load, ex_result,
        output mem_rd, mem_wen, mem_result,
        input  RA, RB, stall,
        input  id_valid, id_wen, id_is_load, id_is_store,
        input  id_is_branch, id_is_jump, id_opcode, id_rd,
        input  id_opA, id_opB, id_imm
    );

    modport slave (
        input  if_valid, if_instr, flush, BusA, BusB,
        input  ex_rd, ex_wen, ex_is_load, ex_result,
        input  mem_rd, mem_wen, mem_result,
        output RA, RB, stall,
        output id_valid, id_wen, id_is_load, id_is_store,
        output id_is_branch, id_is_jump, id_opcode, id_rd,
        output id_opA, id_opB, id_imm
    );
endinterface

// File: rtl/decode_operand_stage.sv
// decode_operand_stage: decodes IF/ID, reads and forwards operands,
// detects load-use hazards and fills the ID/EX register.
module decode_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input logic                 clk,
    input logic                 reset,
    decode_operand_stage_if.slave bus
);
    logic [3:0]        op;
    logic [REG_AW-1:0] f11;
    logic [REG_AW-1:0] f8;
    logic [REG_AW-1:0] f5;
    logic [DATA_W-1:0] sext6;
    logic [DATA_W-1:0] sext12;

    assign op     = bus.if_instr[15:12];
    assign f11    = bus.if_instr[11:9];
    assign f8     = bus.if_instr[8:6];
    assign f5     = bus.if_instr[5:3];
    assign sext6  = {{(DATA_W-6){bus.if_instr[5]}}, bus.if_instr[5:0]};
    assign sext12 = {{(DATA_W-12){bus.if_instr[11]}}, bus.if_instr[11:0]};

    logic [REG_AW-1:0] addrA;
    logic [REG_AW-1:0] addrB;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              isLoad;
    logic              isStore;
    logic              isBranch;
    logic              isJump;
    logic [DATA_W-1:0] imm;

    // Unused source ports stay at address 0, which also masks them
    // out of forwarding and hazard detection below.
    always_comb begin
        addrA    = '0;
        addrB    = '0;
        rd       = '0;
        wen      = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        isBranch = 1'b0;
        isJump   = 1'b0;
        imm      = '0;
        unique case (1'b1)
            op == 4'h0: begin
                addrA = f8;
                addrB = f5;
                rd    = f11;
                wen   = 1'b1;
            end
            op >= 4'h1 && op <= 4'h4: begin
                addrA  = f8;
                rd     = f11;
                wen    = 1'b1;
                isLoad = (op == 4'h4);
                imm    = sext6;
            end
            op == 4'h5: begin
                addrA   = f8;
                addrB   = f11;
                isStore = 1'b1;
                imm     = sext6;
            end
            op == 4'h6: begin
                addrA    = f8;
                addrB    = f11;
                isBranch = 1'b1;
                imm      = sext6;
            end
            op == 4'h7: begin
                isJump = 1'b1;
                imm    = sext12;
            end
            default: ;
        endcase
    end

    assign bus.RA = addrA;
    assign bus.RB = addrB;

    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;

    // EX beats MEM; a load in EX has no data yet and is never a source.
    always_comb begin
        opA = bus.BusA;
        if (addrA == '0)
            opA = '0;
        else if (bus.ex_wen && !bus.ex_is_load && bus.ex_rd == addrA)
            opA = bus.ex_result;
        else if (bus.mem_wen && bus.mem_rd == addrA)
            opA = bus.mem_result;
    end

    always_comb begin
        opB = bus.BusB;
        if (addrB == '0)
            opB = '0;
        else if (bus.ex_wen && !bus.ex_is_load && bus.ex_rd == addrB)
            opB = bus.ex_result;
        else if (bus.mem_wen && bus.mem_rd == addrB)
            opB = bus.mem_result;
    end

    logic loadUse;

    assign loadUse = bus.if_valid && bus.ex_wen && bus.ex_is_load
                  && bus.ex_rd != '0
                  && (bus.ex_rd == addrA || bus.ex_rd == addrB);

    assign bus.stall = loadUse && !bus.flush && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.id_valid     <= 1'b0;
            bus.id_wen       <= 1'b0;
            bus.id_is_load   <= 1'b0;
            bus.id_is_store  <= 1'b0;
            bus.id_is_branch <= 1'b0;
            bus.id_is_jump   <= 1'b0;
            bus.id_opcode    <= '0;
            bus.id_rd        <= '0;
            bus.id_opA       <= '0;
            bus.id_opB       <= '0;
            bus.id_imm       <= '0;
        end else if (bus.flush) begin
            bus.id_valid     <= 1'b0;
            bus.id_wen       <= 1'b0;
            bus.id_is_load   <= 1'b0;
            bus.id_is_store  <= 1'b0;
            bus.id_is_branch <= 1'b0;
            bus.id_is_jump   <= 1'b0;
        end else if (loadUse) begin
            bus.id_valid   <= 1'b0;
            bus.id_wen     <= 1'b0;
            bus.id_is_load <= 1'b0;
        end else begin
            bus.id_valid     <= bus.if_valid;
            bus.id_wen       <= wen;
            bus.id_is_load   <= isLoad;
            bus.id_is_store  <= isStore;
            bus.id_is_branch <= isBranch;
            bus.id_is_jump   <= isJump;
            bus.id_opcode    <= op;
            bus.id_rd        <= rd;
            bus.id_opA       <= opA;
            bus.id_opB       <= opB;
            bus.id_imm       <= imm;
        end
    end
endmodule
